// File: rtl/y86_seq_controller_if.sv
// Stage-control bundle between the SEQ sequencer and the Y86-64 datapath stages.
// The controller owns the stage enables; the datapath reports decode and memory status.
interface y86_seq_controller_if;
    logic [3:0] icode;
    logic       instr_valid;
    logic       imem_error;
    logic       dmem_error;
    logic       mem_ready;
    logic       fetch_en;
    logic       decode_en;
    logic       exec_en;
    logic       cc_en;
    logic       mem_en;
    logic       wb_en;
    logic       pc_en;

    modport master (
        input  icode, instr_valid, imem_error, dmem_error, mem_ready,
        output fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en
    );

    modport slave (
        output icode, instr_valid, imem_error, dmem_error, mem_ready,
        input  fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en
    );
endinterface

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the SEQ Y86-64 datapath: one stage enable per cycle,
// condition-code gating, data-memory stall with timeout, and processor status.
module y86_seq_controller #(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    y86_seq_controller_if.master    stg,
    output logic                    busy,
    output logic [2:0]              stat,
    output logic [CNT_W-1:0]        instr_count,
    output logic [CNT_W-1:0]        cycle_count
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPDATE,
        HALT,
        ERROR
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // wait_cnt counts completed MEMORY cycles, so the last allowed one sees MAX-1
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] stat_nxt;
    logic [7:0] wait_cnt;
    logic       is_mem;

    always_comb begin
        is_mem = 1'b0;
        case (stg.icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (stg.imem_error) begin
                    state_nxt = ERROR;
                    stat_nxt  = STAT_ADR;
                end else if (!stg.instr_valid) begin
                    state_nxt = ERROR;
                    stat_nxt  = STAT_INS;
                end else if (stg.icode == ICODE_HALT) begin
                    state_nxt = HALT;
                    stat_nxt  = STAT_HLT;
                end else begin
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = EXECUTE;
            EXECUTE: state_nxt = MEMORY;
            MEMORY: begin
                if (!is_mem) begin
                    state_nxt = WRITEBACK;
                end else if (stg.dmem_error) begin
                    state_nxt = ERROR;
                    stat_nxt  = STAT_ADR;
                end else if (stg.mem_ready) begin
                    state_nxt = WRITEBACK;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERROR;
                    stat_nxt  = STAT_ADR;
                end
            end
            WRITEBACK: state_nxt = PCUPDATE;
            PCUPDATE:  state_nxt = FETCH;
            HALT:      state_nxt = HALT;
            ERROR:     state_nxt = ERROR;
            default:   state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stat          <= STAT_AOK;
            wait_cnt      <= 8'd0;
            busy          <= 1'b0;
            stg.fetch_en  <= 1'b0;
            stg.decode_en <= 1'b0;
            stg.exec_en   <= 1'b0;
            stg.cc_en     <= 1'b0;
            stg.mem_en    <= 1'b0;
            stg.wb_en     <= 1'b0;
            stg.pc_en     <= 1'b0;
            instr_count   <= '0;
            cycle_count   <= '0;
        end else begin
            state         <= state_nxt;
            stat          <= stat_nxt;
            stg.fetch_en  <= (state_nxt == FETCH);
            stg.decode_en <= (state_nxt == DECODE);
            stg.exec_en   <= (state_nxt == EXECUTE);
            stg.cc_en     <= (state_nxt == EXECUTE) && (stg.icode == ICODE_OPQ);
            stg.mem_en    <= (state_nxt == MEMORY) && is_mem;
            stg.wb_en     <= (state_nxt == WRITEBACK);
            stg.pc_en     <= (state_nxt == PCUPDATE);
            busy          <= !((state_nxt == IDLE) || (state_nxt == HALT) ||
                               (state_nxt == ERROR));
            if ((state == MEMORY) && (state_nxt == MEMORY)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (state == PCUPDATE) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (busy) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed bench for y86_seq_controller: an instruction-level timeline model queues
// the expected outputs per cycle and one compare process checks them.
module tb_y86_seq_controller;

    localparam logic [6:0] EN_F  = 7'b1000000;
    localparam logic [6:0] EN_D  = 7'b0100000;
    localparam logic [6:0] EN_E  = 7'b0010000;
    localparam logic [6:0] EN_CC = 7'b0001000;
    localparam logic [6:0] EN_M  = 7'b0000100;
    localparam logic [6:0] EN_W  = 7'b0000010;
    localparam logic [6:0] EN_P  = 7'b0000001;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
    localparam int MEM_WAIT = 15;

    typedef struct packed {
        logic [6:0]  en;
        logic        busy;
        logic [2:0]  stat;
        logic [31:0] icnt;
        logic [31:0] ccnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [2:0]  stat;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    y86_seq_controller_if ifc();

    y86_seq_controller #(.CNT_W(32), .MEM_WAIT_MAX(MEM_WAIT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stg(ifc.master),
        .busy(busy),
        .stat(stat),
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];
    exp_t cmpExp;
    bit   modelBusy = 1'b0;
    int   modelIcnt = 0;
    int   modelCcnt = 0;
    int   memEnCnt = 0, wbCnt = 0, pcCnt = 0, ccCnt = 0;

    function automatic logic [6:0] enVec();
        return {ifc.fetch_en, ifc.decode_en, ifc.exec_en, ifc.cc_en,
                ifc.mem_en, ifc.wb_en, ifc.pc_en};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic pushExp(input logic [6:0] en, input bit b, input logic [2:0] st,
                           input bit retire);
        exp_t e;
        if (retire) modelIcnt++;
        if (modelBusy) modelCcnt++;
        e.en   = en;
        e.busy = b;
        e.stat = st;
        e.icnt = modelIcnt;
        e.ccnt = modelCcnt;
        expQ.push_back(e);
        modelBusy = b;
    endtask

    task automatic applyStimulus(input bit st, input logic [3:0] ic, input bit iv,
                                 input bit imerr, input bit dmerr, input bit rdy);
        @(negedge clk);
        start           = st;
        ifc.icode       = ic;
        ifc.instr_valid = iv;
        ifc.imem_error  = imerr;
        ifc.dmem_error  = dmerr;
        ifc.mem_ready   = rdy;
    endtask

    function automatic bit isMemOp(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
               (ic == 4'hA) || (ic == 4'hB);
    endfunction

    // One instruction; the entry cycle is IDLE+start or the previous PCUPDATE
    task automatic runInstr(input logic [3:0] ic, input bit fromIdle, input bit iv,
                            input bit imerr, input int readyAt, input int dmerrAt,
                            input bit cutAfterExec);
        applyStimulus(fromIdle, ic, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(EN_F, 1'b1, AOK, !fromIdle);
        applyStimulus(1'b0, ic, iv, imerr, 1'b0, 1'b0);
        if (imerr) begin pushExp(7'b0, 1'b0, ADR, 1'b0); return; end
        if (!iv) begin pushExp(7'b0, 1'b0, INS, 1'b0); return; end
        if (ic == 4'h0) begin pushExp(7'b0, 1'b0, HLT, 1'b0); return; end
        pushExp(EN_D, 1'b1, AOK, 1'b0);
        applyStimulus(1'b0, ic, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp((ic == 4'h6) ? (EN_E | EN_CC) : EN_E, 1'b1, AOK, 1'b0);
        if (cutAfterExec) return;
        applyStimulus(1'b0, ic, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(isMemOp(ic) ? EN_M : 7'b0, 1'b1, AOK, 1'b0);
        if (isMemOp(ic)) begin
            for (int i = 1; i <= MEM_WAIT; i++) begin
                applyStimulus(1'b0, ic, 1'b1, 1'b0, i == dmerrAt, i == readyAt);
                if (i == dmerrAt || (i == MEM_WAIT && i != readyAt)) begin
                    pushExp(7'b0, 1'b0, ADR, 1'b0);
                    return;
                end
                if (i == readyAt) break;
                pushExp(EN_M, 1'b1, AOK, 1'b0);
            end
        end else begin
            applyStimulus(1'b0, ic, 1'b1, 1'b0, 1'b0, readyAt == 1);
        end
        pushExp(EN_W, 1'b1, AOK, 1'b0);
        applyStimulus(1'b0, ic, 1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(EN_P, 1'b1, AOK, 1'b0);
    endtask

    task automatic runIdle(input int n, input bit st, input logic [2:0] expStat);
        for (int i = 0; i < n; i++) begin
            applyStimulus(st, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
            pushExp(7'b0, 1'b0, expStat, 1'b0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Reset lands mid-cycle so its asynchronous effect is visible before any edge
    task automatic doReset();
        settle();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("rst_enables", 32'(enVec()), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_stat", 32'(stat), 32'(AOK));
        checkOutput("rst_instr_count", instr_count, 32'd0);
        checkOutput("rst_cycle_count", cycle_count, 32'd0);
        expQ.delete();
        modelBusy = 1'b0;
        modelIcnt = 0;
        modelCcnt = 0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_hold_enables", 32'(enVec()), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #2;
        if (expQ.size() != 0) begin
            cmpExp = expQ.pop_front();
            checkOutput("enables", 32'(enVec()), 32'(cmpExp.en));
            checkOutput("busy", 32'(busy), 32'(cmpExp.busy));
            checkOutput("stat", 32'(stat), 32'(cmpExp.stat));
            checkOutput("instr_count", instr_count, cmpExp.icnt);
            checkOutput("cycle_count", cycle_count, cmpExp.ccnt);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            memEnCnt += int'(ifc.mem_en);
            wbCnt    += int'(ifc.wb_en);
            pcCnt    += int'(ifc.pc_en);
            ccCnt    += int'(ifc.cc_en);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int memBase, wbBase, pcBase, ccBase;
        ifc.icode = 4'h1;
        ifc.instr_valid = 1'b1;
        ifc.imem_error = 1'b0;
        ifc.dmem_error = 1'b0;
        ifc.mem_ready = 1'b0;

        // OPq then halt: six-cycle instruction, cc_en once
        doReset();
        ccBase = ccCnt; memBase = memEnCnt;
        runIdle(2, 1'b0, AOK);
        runInstr(4'h6, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        runInstr(4'h0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        checkOutput("t1_instr_count", instr_count, 32'd1);
        checkOutput("t1_cycle_count", cycle_count, 32'd7);
        checkOutput("t1_cc_pulses", 32'(ccCnt - ccBase), 32'd1);
        checkOutput("t1_mem_pulses", 32'(memEnCnt - memBase), 32'd0);

        // mrmovq ready on third MEMORY cycle: eight cycles
        doReset();
        memBase = memEnCnt;
        runInstr(4'h5, 1'b1, 1'b1, 1'b0, 3, 0, 1'b0);
        runInstr(4'h0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        checkOutput("t2_mem_pulses", 32'(memEnCnt - memBase), 32'd3);
        checkOutput("t2_cycle_count", cycle_count, 32'd9);
        checkOutput("t2_stat", 32'(stat), 32'(HLT));

        // pushq never ready: timeout fault
        doReset();
        memBase = memEnCnt; wbBase = wbCnt; pcBase = pcCnt;
        runInstr(4'hA, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        runIdle(3, 1'b1, ADR);
        settle();
        checkOutput("t3_mem_pulses", 32'(memEnCnt - memBase), 32'd15);
        checkOutput("t3_wb_pulses", 32'(wbCnt - wbBase), 32'd0);
        checkOutput("t3_pc_pulses", 32'(pcCnt - pcBase), 32'd0);
        checkOutput("t3_stat", 32'(stat), 32'd3);

        // Two nops then halt; start ignored afterwards
        doReset();
        runInstr(4'h1, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
        runInstr(4'h1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        runInstr(4'h0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        runIdle(4, 1'b1, HLT);
        settle();
        checkOutput("t4_instr_count", instr_count, 32'd2);
        checkOutput("t4_stat", 32'(stat), 32'd2);

        // Fetch faults: ADR beats INS
        doReset();
        runInstr(4'h6, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        runIdle(1, 1'b1, ADR);
        doReset();
        runInstr(4'h6, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        runIdle(1, 1'b1, INS);
        settle();
        checkOutput("t5_stat_ins", 32'(stat), 32'd4);

        // Memory edge cases: ready on first cycle, dmem_error beats mem_ready
        doReset();
        runInstr(4'h5, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
        runInstr(4'h4, 1'b0, 1'b1, 1'b0, 2, 2, 1'b0);
        runIdle(2, 1'b0, ADR);

        // Reset during cmovXX EXECUTE, then a clean restart
        doReset();
        runInstr(4'h2, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        doReset();
        runInstr(4'h2, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        runInstr(4'h6, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        runInstr(4'h0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        checkOutput("t6_instr_count", instr_count, 32'd2);
        checkOutput("t6_stat", 32'(stat), 32'(HLT));
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
